// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-neuron blocks (LIF neuron and STDP learner).
package snn_pkg;

  localparam logic [0:0] ST_INTEGRATE = 1'b0;
  localparam logic [0:0] ST_REFRACT   = 1'b1;

  // The STDP weight output and the neuron weight input must agree on this width.
  localparam int SNN_W_WIDTH = 8;
  localparam int SPIKE_CNT_W = 16;

  function automatic logic [SPIKE_CNT_W-1:0] sat_inc(input logic [SPIKE_CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/refrac_timer.sv
// Refractory countdown: loads REFRAC_CYCLES-1 on a spike, counts down on enabled cycles.
module refrac_timer
  import snn_pkg::*;
#(
  parameter int REFRAC_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  output logic done
);

  localparam int CW = (REFRAC_CYCLES > 1) ? $clog2(REFRAC_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(REFRAC_CYCLES - 1);

  logic [CW-1:0] cnt;

  // NOTE: reset is sampled on the clock edge, so it sits inside the clocked block
  // and is not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (run && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron with shift leak, saturating integration and refractory period.
module lif_neuron
  import snn_pkg::*;
#(
  parameter int V_WIDTH       = 12,
  parameter int W_WIDTH       = SNN_W_WIDTH,
  parameter int THRESHOLD     = 200,
  parameter int LEAK_SHIFT    = 3,
  parameter int REFRAC_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   pre_spike,
  input  logic [W_WIDTH-1:0]     weight,
  output logic                   post_spike,
  output logic [V_WIDTH-1:0]     membrane,
  output logic                   refractory,
  output logic [SPIKE_CNT_W-1:0] spike_count
);

  localparam logic [V_WIDTH-1:0] TH_V = V_WIDTH'(THRESHOLD);

  logic [0:0]         state;
  logic [V_WIDTH-1:0] leak_raw, leak, in_v, v_next;
  logic [V_WIDTH:0]   sum;
  logic               fire, t_done;

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    leak_raw = membrane >> LEAK_SHIFT;
    leak     = '0;
    if (membrane != '0) leak = (leak_raw == '0) ? V_WIDTH'(1) : leak_raw;
    in_v = pre_spike ? V_WIDTH'(weight) : '0;
    // v - leak never underflows, so one extra bit captures any overflow from the add.
    sum    = {1'b0, membrane} - {1'b0, leak} + {1'b0, in_v};
    v_next = sum[V_WIDTH] ? '1 : sum[V_WIDTH-1:0];
    fire   = (state == ST_INTEGRATE) && (v_next >= TH_V);
  end

  refrac_timer #(.REFRAC_CYCLES(REFRAC_CYCLES)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (en && fire),
    .run   (en && state == ST_REFRACT),
    .done  (t_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_INTEGRATE;
      membrane    <= '0;
      post_spike  <= 1'b0;
      spike_count <= '0;
    end else if (!en) begin
      post_spike <= 1'b0;
    end else if (state == ST_INTEGRATE) begin
      if (fire) begin
        post_spike  <= 1'b1;
        membrane    <= '0;
        state       <= ST_REFRACT;
        spike_count <= sat_inc(spike_count);
      end else begin
        post_spike <= 1'b0;
        membrane   <= v_next;
      end
    end else begin
      // Incoming spikes are dropped while refractory.
      post_spike <= 1'b0;
      membrane   <= '0;
      if (t_done) state <= ST_INTEGRATE;
    end
  end

  assign refractory = (state == ST_REFRACT);

endmodule
